// File: rtl/apb_regbank_completer.sv
// APB completer with a small byte-strobed register bank, programmable wait states
// and error responses for misaligned, out-of-range and read-only-write accesses.
module apb_regbank_completer #(
  parameter int          ADDR_WIDTH = 32,
  parameter int          DATA_WIDTH = 32,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter int          NUM_REGS   = 8,
  parameter logic [31:0] ID_VALUE   = 32'hA5B0_0001
) (
  input  logic                  pclk,
  input  logic                  preset,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic [STRB_WIDTH-1:0] pstrb,
  input  logic [2:0]            pprot,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic                  pready,
  output logic                  pslverr
);

  localparam int IW = $clog2(NUM_REGS);
  localparam logic [ADDR_WIDTH-1:0] ADDR_LIMIT = ADDR_WIDTH'(NUM_REGS * 4);

  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] ACCESS = 1'b1;

  logic [0:0]            state_reg;
  logic [3:0]            cnt_reg;
  logic [IW-1:0]         idx_reg;
  logic                  write_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic [STRB_WIDTH-1:0] strb_reg;
  logic                  err_reg;
  logic [DATA_WIDTH-1:0] prdata_reg;

  logic [DATA_WIDTH-1:0] word_rd [NUM_REGS];
  logic [IW-1:0]         idx;
  logic                  setup;
  logic                  req_err;
  logic                  complete;
  logic                  commit;
  logic                  unused_pprot;

  assign unused_pprot = ^pprot;

  assign idx     = paddr[IW+1:2];
  assign setup   = psel & ~penable;
  assign req_err = (paddr[1:0] != 2'b00) | (paddr >= ADDR_LIMIT) |
                   (pwrite & (idx == IW'(1)));

  assign complete = (state_reg == ACCESS) & psel & penable & (cnt_reg == 4'd0);
  // Errored writes complete with a response but never touch the bank.
  assign commit   = complete & write_reg & ~err_reg;

  assign pready  = complete;
  assign pslverr = complete & err_reg;
  assign prdata  = prdata_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      if (gi == 0) begin : g_wait
        logic [3:0] wait_reg;
        always_ff @(posedge pclk) begin
          if (preset)
            wait_reg <= 4'd0;
          else if (commit && idx_reg == IW'(gi) && strb_reg[0])
            wait_reg <= wdata_reg[3:0];
        end
        assign word_rd[gi] = {{(DATA_WIDTH-4){1'b0}}, wait_reg};
      end else if (gi == 1) begin : g_id
        assign word_rd[gi] = ID_VALUE;
      end else begin : g_scratch
        logic [DATA_WIDTH-1:0] scratch_reg;
        always_ff @(posedge pclk) begin
          if (preset)
            scratch_reg <= '0;
          else if (commit && idx_reg == IW'(gi)) begin
            for (int k = 0; k < STRB_WIDTH; k++)
              if (strb_reg[k])
                scratch_reg[8*k +: 8] <= wdata_reg[8*k +: 8];
          end
        end
        assign word_rd[gi] = scratch_reg;
      end
    end
  endgenerate

  always_ff @(posedge pclk) begin
    if (preset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      idx_reg    <= '0;
      write_reg  <= 1'b0;
      wdata_reg  <= '0;
      strb_reg   <= '0;
      err_reg    <= 1'b0;
      prdata_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          // penable without a preceding setup phase is ignored here.
          if (setup) begin
            state_reg  <= ACCESS;
            idx_reg    <= idx;
            write_reg  <= pwrite;
            wdata_reg  <= pwdata;
            strb_reg   <= pstrb;
            err_reg    <= req_err;
            cnt_reg    <= word_rd[0][3:0];
            prdata_reg <= (!pwrite && !req_err) ? word_rd[idx] : '0;
          end
        end
        ACCESS: begin
          if (!psel) begin
            state_reg  <= IDLE;
            prdata_reg <= '0;
          end else if (penable) begin
            if (cnt_reg != 4'd0) begin
              cnt_reg <= cnt_reg - 4'd1;
            end else begin
              state_reg  <= IDLE;
              prdata_reg <= '0;
            end
          end
        end
        default: begin
          state_reg  <= IDLE;
          prdata_reg <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_regbank_completer.sv
// Directed bench for apb_regbank_completer: register map, strobes, wait states,
// error responses, abort and mid-transfer reset.
module tb_apb_regbank_completer;

  logic        pclk = 1'b0;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int n_checks = 0;
  int n_pass   = 0;

  logic [31:0] rd;
  logic        err;
  int          ncyc;

  always #5 pclk = ~pclk;

  apb_regbank_completer dut (
    .pclk    (pclk),
    .preset  (preset),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .pstrb   (pstrb),
    .pprot   (pprot),
    .prdata  (prdata),
    .pready  (pready),
    .pslverr (pslverr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %-20s got=%08h", tag, got);
    end else begin
      $display("FAIL %-20s got=%08h expected=%08h", tag, got, exp);
    end
  endtask

  // One complete transfer; ncyc is the number of access cycles up to and
  // including the one with pready, or -1 if pready never arrived.
  task automatic apb_xfer(input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output logic [31:0] rdata,
                          output logic rerr, output int cycles);
    logic done;
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    done = 1'b0; cycles = -1; rdata = '0; rerr = 1'b0;
    for (int i = 1; i <= 40 && !done; i++) begin
      @(negedge pclk);
      if (pready) begin
        rdata = prdata; rerr = pslverr; cycles = i; done = 1'b1;
      end else begin
        @(posedge pclk); #1;
      end
    end
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, input logic exp_err, input int exp_cyc);
    apb_xfer(1'b1, a, d, s, rd, err, ncyc);
    $display("write %-16s addr=%08h data=%08h strb=%b err=%0b cyc=%0d", tag, a, d, s, err, ncyc);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".cyc"}, ncyc, exp_cyc);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                         input logic exp_err, input int exp_cyc);
    apb_xfer(1'b0, a, 32'h0, 4'h0, rd, err, ncyc);
    $display("read  %-16s addr=%08h data=%08h err=%0b cyc=%0d", tag, a, rd, err, ncyc);
    check({tag, ".data"}, rd, exp_d);
    check({tag, ".err"}, {31'b0, err}, {31'b0, exp_err});
    check({tag, ".cyc"}, ncyc, exp_cyc);
  endtask

  initial begin
    preset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = 3'b000;
    repeat (2) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("rst.prdata", prdata, 32'h0);
    check("rst.pready", {31'b0, pready}, 32'h0);
    check("rst.pslverr", {31'b0, pslverr}, 32'h0);

    // penable without setup phase must be ignored
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b1; paddr = 32'h4;
    @(posedge pclk); @(negedge pclk);
    check("nosetup.pready", {31'b0, pready}, 32'h0);
    #1 psel = 1'b0; penable = 1'b0;

    do_read("id", 32'h4, 32'hA5B0_0001, 1'b0, 1);

    do_write("r2.strb5", 32'h8, 32'hDEAD_BEEF, 4'b0101, 1'b0, 1);
    do_read("r2.partial", 32'h8, 32'h00AD_00EF, 1'b0, 1);
    do_write("r2.full", 32'h8, 32'hFFFF_FFFF, 4'hF, 1'b0, 1);
    do_read("r2.full", 32'h8, 32'hFFFF_FFFF, 1'b0, 1);

    // WAIT upper bits ignored; W=3 gives 4 access cycles
    do_write("wait3", 32'h0, 32'hFFFF_FFF3, 4'hF, 1'b0, 1);
    do_read("r2.w3", 32'h8, 32'hFFFF_FFFF, 1'b0, 4);
    do_read("wait.rd3", 32'h0, 32'h0000_0003, 1'b0, 4);
    do_write("wait15", 32'h0, 32'h0000_000F, 4'h1, 1'b0, 4);
    do_read("wait.rd15", 32'h0, 32'h0000_000F, 1'b0, 16);
    do_write("wait0", 32'h0, 32'h0, 4'h1, 1'b0, 16);
    do_read("r2.w0", 32'h8, 32'hFFFF_FFFF, 1'b0, 1);

    do_write("r3.init", 32'hC, 32'h1122_3344, 4'hF, 1'b0, 1);
    do_write("r3.nostrb", 32'hC, 32'hAAAA_AAAA, 4'h0, 1'b0, 1);
    do_write("err.id", 32'h4, 32'h0, 4'hF, 1'b1, 1);
    do_write("err.range", 32'h20, 32'h0000_0005, 4'hF, 1'b1, 1);
    do_write("err.misalign", 32'hE, 32'h0, 4'hF, 1'b1, 1);
    do_read("err.rd6", 32'h6, 32'h0, 1'b1, 1);
    do_read("id.after", 32'h4, 32'hA5B0_0001, 1'b0, 1);
    do_read("wait.alias", 32'h0, 32'h0, 1'b0, 1);
    do_read("r3.kept", 32'hC, 32'h1122_3344, 1'b0, 1);

    // abort: W=5, drop psel after 2 access cycles
    do_write("wait5", 32'h0, 32'h5, 4'h1, 1'b0, 1);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'h1234_5678; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge pclk);
      check("abort.pready", {31'b0, pready}, 32'h0);
      @(posedge pclk); #1;
    end
    psel = 1'b0; penable = 1'b0;
    $display("abort write reg3 after 2 access cycles");
    do_read("r3.abort", 32'hC, 32'h1122_3344, 1'b0, 6);

    // reset during a W=4 write access
    do_write("wait4", 32'h0, 32'h4, 4'h1, 1'b0, 6);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hAAAA_5555; pstrb = 4'hF;
    @(posedge pclk); #1 penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1 preset = 1'b1;
    @(posedge pclk); #1;
    $display("reset asserted mid write access");
    check("rst2.pready", {31'b0, pready}, 32'h0);
    check("rst2.prdata", prdata, 32'h0);
    check("rst2.pslverr", {31'b0, pslverr}, 32'h0);
    preset = 1'b0; psel = 1'b0; penable = 1'b0;
    do_read("wait.rst", 32'h0, 32'h0, 1'b0, 1);
    do_read("r3.rst", 32'hC, 32'h0, 1'b0, 1);
    do_read("r2.rst", 32'h8, 32'h0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
